// File: rtl/stream_adder_tree_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : stream_adder_tree_acc
// Brief    : Streaming signed adder tree with valid/ready pipeline stages and
//            optional multi-beat packet accumulation.
//            Optional macro ADDER_TREE_ACC_SAT_EN: saturating accumulation.
// Revision : 1.0 - initial release
// ============================================================================
module stream_adder_tree_acc #(
    parameter int              NUM_INPUTS      = 8,
    parameter int              INPUT_WIDTH     = 8,
    parameter int              LEVELS          = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0,
    parameter logic [LEVELS:0] PIPE_STAGE_MASK = '0,
    parameter int              MAX_BEATS       = 16,
    parameter int              CNT_WIDTH       = $clog2(MAX_BEATS + 1),
    parameter int              ACC_WIDTH       = INPUT_WIDTH + LEVELS + $clog2(MAX_BEATS)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0] in_data,
    input  logic                                   in_last,
    input  logic                                   acc_en,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic signed [ACC_WIDTH-1:0]            out_sum,
    output logic [CNT_WIDTH-1:0]                   out_count,
    output logic                                   overflow
);

    localparam int TREE_WIDTH = INPUT_WIDTH + LEVELS;

    logic                         acc_ready;
    logic                         tree_valid;
    logic                         tree_last;
    logic                         tree_mode;
    logic signed [TREE_WIDTH-1:0] tree_sum;

    // Boundary k carries the 2**(LEVELS-k) partial sums entering layer k.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int LANES = 1 << (LEVELS - k);
        localparam int W     = INPUT_WIDTH + k;

        logic [LANES-1:0][W-1:0] d_in;
        logic [LANES-1:0][W-1:0] d_out;
        logic                    v_in;
        logic                    v_out;
        logic                    ready_in;
        logic                    ready_out;
        logic [1:0]              tag_in;   // {acc_en, last}
        logic [1:0]              tag_out;

        if (k == 0) begin : g_src
            assign v_in     = in_valid;
            assign tag_in   = {acc_en, in_last};
            assign in_ready = ready_in;
            for (genvar j = 0; j < LANES; j++) begin : g_lane
                if (j < NUM_INPUTS) begin : g_live
                    assign d_in[j] = in_data[j];
                end else begin : g_pad
                    assign d_in[j] = '0;
                end
            end
        end else begin : g_add
            assign v_in   = g_lvl[k-1].v_out;
            assign tag_in = g_lvl[k-1].tag_out;
            for (genvar j = 0; j < LANES; j++) begin : g_pair
                assign d_in[j] = W'($signed(g_lvl[k-1].d_out[2*j]))
                               + W'($signed(g_lvl[k-1].d_out[2*j+1]));
            end
        end

        if (k == LEVELS) begin : g_sink
            assign ready_out = acc_ready;
        end else begin : g_link
            assign ready_out = g_lvl[k+1].ready_in;
        end

        if (PIPE_STAGE_MASK[k]) begin : g_reg
            assign ready_in = !v_out || ready_out;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_out <= 1'b0;
                end else if (ready_in) begin
                    v_out <= v_in;
                end
            end

            always_ff @(posedge clk) begin
                if (ready_in) begin
                    d_out   <= d_in;
                    tag_out <= tag_in;
                end
            end
        end else begin : g_pass
            assign ready_in = ready_out;
            assign v_out    = v_in;
            assign d_out    = d_in;
            assign tag_out  = tag_in;
        end
    end

    assign tree_valid = g_lvl[LEVELS].v_out;
    assign tree_sum   = g_lvl[LEVELS].d_out[0];
    assign tree_mode  = g_lvl[LEVELS].tag_out[1];
    assign tree_last  = g_lvl[LEVELS].tag_out[0];

    logic                        mid;
    logic                        mode;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_nxt;
    logic signed [ACC_WIDTH-1:0] sum_ext;
    logic [CNT_WIDTH-1:0]        cnt;
    logic [CNT_WIDTH-1:0]        cnt_nxt;
    logic                        cur_mode;
    logic                        is_final;
    logic                        take;

    // Per-beat mode is the accumulate path with an empty accumulator.
    assign sum_ext   = ACC_WIDTH'(tree_sum);
    assign cur_mode  = mid ? mode : tree_mode;
    assign is_final  = !cur_mode || tree_last;
    assign acc_ready = !is_final || !out_valid || out_ready;
    assign take      = tree_valid && acc_ready;

`ifdef ADDER_TREE_ACC_SAT_EN
    logic signed [ACC_WIDTH-1:0] acc_raw;
    logic                        pkt_ovf;
    logic                        ovf_nxt;

    always_comb begin
        acc_raw = acc + sum_ext;
        acc_nxt = acc_raw;
        ovf_nxt = pkt_ovf;
        if ((acc[ACC_WIDTH-1] == sum_ext[ACC_WIDTH-1]) &&
            (acc_raw[ACC_WIDTH-1] != acc[ACC_WIDTH-1])) begin
            acc_nxt = acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            ovf_nxt = 1'b1;
        end
        cnt_nxt = (cnt >= CNT_WIDTH'(MAX_BEATS)) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_ovf  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                overflow <= 1'b0;
            end
            if (take) begin
                if (is_final) begin
                    overflow <= ovf_nxt;
                    pkt_ovf  <= 1'b0;
                end else begin
                    pkt_ovf  <= ovf_nxt;
                end
            end
        end
    end
`else
    always_comb begin
        acc_nxt = acc + sum_ext;
        cnt_nxt = cnt + 1'b1;
    end

    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            acc       <= '0;
            cnt       <= '0;
            mid       <= 1'b0;
            mode      <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (take) begin
                if (!mid) begin
                    mode <= tree_mode;
                end
                if (is_final) begin
                    out_valid <= 1'b1;
                    out_sum   <= acc_nxt;
                    out_count <= cnt_nxt;
                    acc       <= '0;
                    cnt       <= '0;
                    mid       <= 1'b0;
                end else begin
                    acc <= acc_nxt;
                    cnt <= cnt_nxt;
                    mid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_adder_tree_acc.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for stream_adder_tree_acc: 8-lane pipelined instance with a
// packet-level scoreboard, plus a 5-lane unregistered instance.
module tb_stream_adder_tree_acc;

    localparam int         N    = 8;
    localparam int         IW   = 8;
    localparam int         MB   = 20;
    localparam int         AW   = 12;
    localparam int         CW   = 5;
    localparam logic [3:0] MASK = 4'b1011;
    localparam int         NP   = 3;
    localparam int         N5   = 5;
    localparam int         AW5  = 15;
    localparam int         CW5  = 5;
    localparam longint     MAXV = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint     MINV = -(64'sd1 <<< (AW - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [N-1:0][IW-1:0]     in_data = '0;
    logic                     in_last = 1'b0;
    logic                     acc_en = 1'b0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [AW-1:0]     out_sum;
    logic [CW-1:0]            out_count;
    logic                     overflow;

    logic                     d5_in_valid = 1'b0;
    logic                     d5_in_ready;
    logic [N5-1:0][IW-1:0]    d5_in_data = '0;
    logic                     d5_in_last = 1'b0;
    logic                     d5_acc_en = 1'b0;
    logic                     d5_out_valid;
    logic                     d5_out_ready = 1'b1;
    logic signed [AW5-1:0]    d5_out_sum;
    logic [CW5-1:0]           d5_out_count;
    logic                     d5_overflow;

    stream_adder_tree_acc #(
        .NUM_INPUTS(N), .INPUT_WIDTH(IW), .PIPE_STAGE_MASK(MASK),
        .MAX_BEATS(MB), .ACC_WIDTH(AW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .acc_en(acc_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .overflow(overflow)
    );

    stream_adder_tree_acc #(
        .NUM_INPUTS(N5), .INPUT_WIDTH(IW), .PIPE_STAGE_MASK(4'b0000)
    ) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(d5_in_valid), .in_ready(d5_in_ready),
        .in_data(d5_in_data), .in_last(d5_in_last), .acc_en(d5_acc_en),
        .out_valid(d5_out_valid), .out_ready(d5_out_ready), .out_sum(d5_out_sum),
        .out_count(d5_out_count), .overflow(d5_overflow)
    );

    typedef struct {
        logic [AW-1:0] sum;
        logic [CW-1:0] cnt;
        logic          ovf;
    } exp_t;

    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_fail = 0;
    bit     rnd_rdy = 1'b0;

    // Packet-level reference: whole packets are summed on the input side.
    bit            m_mid = 1'b0;
    bit            m_mode = 1'b0;
    longint        m_acc = 0;
    int            m_cnt = 0;
    bit            m_ovf = 1'b0;
    bit            hold = 1'b0;
    logic [AW-1:0] h_sum;
    logic [CW-1:0] h_cnt;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_mid = 1'b0; m_mode = 1'b0; m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
            hold = 1'b0;
        end else begin
            if (hold) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_sum !== h_sum || out_count !== h_cnt) begin
                    n_fail++;
                    $display("FAIL hold_stable: got valid=%b sum=%0d cnt=%0d, need valid=1 sum=%0d cnt=%0d",
                             out_valid, out_sum, out_count, $signed(h_sum), h_cnt);
                end
            end
            hold  = out_valid && !out_ready;
            h_sum = out_sum;
            h_cnt = out_count;

            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got sum=%0d cnt=%0d, need no output",
                             out_sum, out_count);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_sum !== e.sum || out_count !== e.cnt || overflow !== e.ovf) begin
                        n_fail++;
                        $display("FAIL scoreboard: got sum=%0d cnt=%0d ovf=%b, need sum=%0d cnt=%0d ovf=%b",
                                 out_sum, out_count, overflow, $signed(e.sum), e.cnt, e.ovf);
                    end
                end
            end

            if (in_valid && in_ready) begin
                int s;
                s = 0;
                for (int j = 0; j < N; j++) s += int'($signed(in_data[j]));
                if (!m_mid) m_mode = acc_en;
                m_acc += s;
`ifdef ADDER_TREE_ACC_SAT_EN
                if (m_acc > MAXV) begin m_acc = MAXV; m_ovf = 1'b1; end
                else if (m_acc < MINV) begin m_acc = MINV; m_ovf = 1'b1; end
                if (m_cnt < MB) m_cnt++;
`else
                m_cnt++;
`endif
                if (!m_mode || in_last) begin
                    exp_t e;
                    e.sum = m_acc[AW-1:0];
                    e.cnt = m_cnt[CW-1:0];
                    e.ovf = m_ovf;
                    exp_q.push_back(e);
                    m_mid = 1'b0; m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
                end else begin
                    m_mid = 1'b1;
                end
            end
        end
    end

    function automatic logic [N-1:0][IW-1:0] fill(input logic [IW-1:0] v);
        for (int j = 0; j < N; j++) fill[j] = v;
    endfunction

    function automatic logic [N-1:0][IW-1:0] rnd_lanes();
        for (int j = 0; j < N; j++) rnd_lanes[j] = IW'($urandom_range(0, 255));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0][IW-1:0] d, input logic last, input logic ae);
        int w;
        w = 0;
        in_data = d; in_last = last; acc_en = ae; in_valid = 1'b1;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        while (!in_ready && w < 200) begin
            tick();
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: got in_ready=%b after %0d cycles, need 1", in_ready, w);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && w < 300) begin
            tick();
            w++;
        end
        n_cmp++;
        if (w >= 300) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, need 0", exp_q.size());
        end
    endtask

    task automatic wait_out(input string name);
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got out_valid=0, need 1", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b sum=%0d cnt=%0d ovf=%b, need all 0",
                     out_valid, out_sum, out_count, overflow);
        end
        n_cmp++;
        if (d5_out_valid !== 1'b0 || d5_out_sum !== '0 || d5_out_count !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs5: got valid=%b sum=%0d cnt=%0d, need all 0",
                     d5_out_valid, d5_out_sum, d5_out_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || d5_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b/%b, need 1/1", in_ready, d5_in_ready);
        end
        tick();
    endtask

    task automatic test_narrow();
        for (int t = 0; t < 6; t++) begin
            int s;
            logic [AW5-1:0] e5;
            s = 0;
            for (int j = 0; j < N5; j++) begin
                if (t == 0)      d5_in_data[j] = 8'd127;
                else if (t == 1) d5_in_data[j] = 8'h80;
                else             d5_in_data[j] = IW'($urandom_range(0, 255));
                s += int'($signed(d5_in_data[j]));
            end
            e5 = AW5'(s);
            d5_in_valid = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (d5_in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL narrow_in_ready[%0d]: got %b, need 1", t, d5_in_ready);
            end
            tick();
            d5_in_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (d5_out_valid !== 1'b1 || d5_out_sum !== e5 || d5_out_count !== 5'd1 ||
                d5_overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL narrow_sum[%0d]: got valid=%b sum=%0d cnt=%0d ovf=%b, need valid=1 sum=%0d cnt=1 ovf=0",
                         t, d5_out_valid, d5_out_sum, d5_out_count, d5_overflow, s);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int first_out;
        int nvalid;
        logic [AW-1:0] rec[3];
        first_out = -1;
        nvalid = 0;
        out_ready = 1'b1;
        acc_en = 1'b0;
        in_last = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                in_data = (c < 3) ? fill(IW'(c + 1)) : rnd_lanes();
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 8) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready[%0d]: got %b, need 1", c, in_ready);
                end
            end
            if (out_valid === 1'b1) begin
                if (first_out < 0) first_out = c;
                if (nvalid < 3) rec[nvalid] = out_sum;
                nvalid++;
            end
            tick();
        end
        n_cmp++;
        if (first_out != NP + 1) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d cycles, need %0d", first_out, NP + 1);
        end
        n_cmp++;
        if (nvalid != 8 || rec[0] !== 12'd8 || rec[1] !== 12'd16 || rec[2] !== 12'd24) begin
            n_fail++;
            $display("FAIL b2b_sums: got n=%0d first=%0d,%0d,%0d, need n=8 first=8,16,24",
                     nvalid, rec[0], rec[1], rec[2]);
        end
    endtask

    task automatic test_accumulate();
        drain();
        for (int b = 0; b < 4; b++) send(fill(8'd1), 1'(b == 3), 1'b1);
        wait_out("acc4");
        n_cmp++;
        if (out_sum !== 12'd32 || out_count !== 5'd4) begin
            n_fail++;
            $display("FAIL acc4: got sum=%0d cnt=%0d, need sum=32 cnt=4", out_sum, out_count);
        end
        tick();
        send(fill(8'hFF), 1'b1, 1'b1);
        wait_out("acc1");
        n_cmp++;
        if (out_sum !== 12'hFF8 || out_count !== 5'd1) begin
            n_fail++;
            $display("FAIL acc1: got sum=%0d cnt=%0d, need sum=-8 cnt=1", out_sum, out_count);
        end
        tick();
        rnd_rdy = 1'b1;
        for (int p = 0; p < 12; p++) begin
            int len;
            logic ae;
            len = $urandom_range(1, 5);
            ae = 1'($urandom_range(0, 1));
            for (int b = 0; b < len; b++) begin
                send(rnd_lanes(), 1'(b == len - 1), ae);
                if ($urandom_range(0, 3) == 0) tick();
            end
        end
        drain();
    endtask

    task automatic test_stall();
        int k;
        int w;
        drain();
        out_ready = 1'b0;
        acc_en = 1'b0;
        in_last = 1'b0;
        k = 1;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data = fill(IW'(k));
            @(negedge clk);
            if (in_ready) k++;
            tick();
        end
        n_cmp++;
        if (k - 1 != NP + 1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_fill: got accepted=%0d in_ready=%b, need accepted=%0d in_ready=0",
                     k - 1, in_ready, NP + 1);
        end
        out_ready = 1'b1;
        w = 0;
        while (k <= 12 && w < 100) begin
            in_valid = 1'b1;
            in_data = fill(IW'(k));
            @(negedge clk);
            if (in_ready) k++;
            tick();
            w++;
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        drain();
        send(fill(8'd2), 1'b0, 1'b1);
        send(fill(8'd2), 1'b0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            if (c == 2) rst_n = 1'b0;
            if (c == 4) rst_n = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet[%0d]: got out_valid=%b, need 0", c, out_valid);
            end
            tick();
        end
        send(fill(8'd2), 1'b0, 1'b1);
        send(fill(8'd2), 1'b1, 1'b1);
        wait_out("reset_mid");
        n_cmp++;
        if (out_sum !== 12'd32 || out_count !== 5'd2) begin
            n_fail++;
            $display("FAIL reset_mid_next: got sum=%0d cnt=%0d, need sum=32 cnt=2", out_sum, out_count);
        end
        tick();
    endtask

    task automatic test_saturate();
        logic [AW-1:0] es;
        logic          eo;
`ifdef ADDER_TREE_ACC_SAT_EN
        es = 12'h7FF; eo = 1'b1;
`else
        es = 12'hF60; eo = 1'b0;
`endif
        drain();
        for (int b = 0; b < 20; b++) send(fill(8'd127), 1'(b == 19), 1'b1);
        wait_out("sat");
        n_cmp++;
        if (out_sum !== es || overflow !== eo || out_count !== 5'd20) begin
            n_fail++;
            $display("FAIL sat20: got sum=%0d cnt=%0d ovf=%b, need sum=%0d cnt=20 ovf=%b",
                     out_sum, out_count, overflow, $signed(es), eo);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clear: got valid=%b ovf=%b, need 0/0", out_valid, overflow);
        end
        tick();
        rnd_rdy = 1'b1;
        for (int p = 0; p < 10; p++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) send(rnd_lanes(), 1'(b == len - 1), 1'b1);
        end
        drain();
    endtask

    initial begin
        #1;
        test_reset();
        test_narrow();
        test_back_to_back();
        test_accumulate();
        test_stall();
        test_reset_mid();
        test_saturate();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d unconsumed results, need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion by time limit, need completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
